snoop_emitter: RTL and testbench

SNOOP_EMITTER -- requirements
Module: snoop_emitter

---
 rtl/snoop_emitter.sv | 138 +++++++++++++
 tb/tb_snoop_emitter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_emitter.sv
// Direct-mapped MSI line tracker that emits snoop bus operations for CPU reads/writes.
// Define SNOOP_EMITTER_WRITEBACK_EN to issue WRITE_BACK before evicting a MODIFIED victim.
module snoop_emitter #(
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 2
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_CpuValid,
  input  logic              i_CpuWrite,
  input  logic [ADDR_W-1:0] i_CpuAddr,
  output logic              o_CpuReady,
  output logic              o_Busy,
  output logic              o_BusValid,
  output logic [1:0]        o_BusOperation,
  output logic [ADDR_W-1:0] o_BusAddr,
  input  logic              i_BusGrant,
  output logic [1:0]        o_LineState
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 2 ** INDEX_W;

  localparam logic [1:0] MSI_I = 2'd0;
  localparam logic [1:0] MSI_S = 2'd1;
  localparam logic [1:0] MSI_M = 2'd2;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, BUS_REQ, DONE} state_t;
  typedef enum logic [1:0] {
    OP_READ_MISS  = 2'd0,
    OP_INVALIDATE = 2'd1,
    OP_WRITE_MISS = 2'd2,
    OP_WRITE_BACK = 2'd3
  } bus_op_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [TAG_W-1:0]  tag_mem [LINES];
  logic [1:0]        msi_mem [LINES];
  bus_op_t           bus_op_q;
  logic [ADDR_W-1:0] bus_addr_q;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   req_tag;
  logic [TAG_W-1:0]   line_tag;
  logic [1:0]         line_msi;
  logic               hit;
  logic               need_wb;
  bus_op_t            miss_op;

  assign index    = addr_q[INDEX_W-1:0];
  assign req_tag  = addr_q[ADDR_W-1:INDEX_W];
  assign line_tag = tag_mem[index];
  assign line_msi = msi_mem[index];
  assign hit      = (line_msi != MSI_I) && (line_tag == req_tag);
  assign miss_op  = write_q ? OP_WRITE_MISS : OP_READ_MISS;

`ifdef SNOOP_EMITTER_WRITEBACK_EN
  assign need_wb = !hit && (line_msi == MSI_M);
`else
  assign need_wb = 1'b0;
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_CpuValid) next_state = LOOKUP;
      LOOKUP: begin
        if (hit) next_state = (write_q && line_msi == MSI_S) ? BUS_REQ : DONE;
        else     next_state = need_wb ? WB_REQ : BUS_REQ;
      end
      WB_REQ:  if (i_BusGrant) next_state = BUS_REQ;
      BUS_REQ: if (i_BusGrant) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus operation/address are loaded on entry to a request state so they stay frozen until granted.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      bus_op_q   <= OP_READ_MISS;
      bus_addr_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_mem[i] <= '0;
        msi_mem[i] <= MSI_I;
      end
    end else begin
      case (state)
        IDLE: begin
          if (i_CpuValid) begin
            addr_q  <= i_CpuAddr;
            write_q <= i_CpuWrite;
          end
        end
        LOOKUP: begin
          if (next_state == WB_REQ) begin
            bus_op_q   <= OP_WRITE_BACK;
            bus_addr_q <= {line_tag, index};
          end else if (next_state == BUS_REQ) begin
            bus_op_q   <= hit ? OP_INVALIDATE : miss_op;
            bus_addr_q <= addr_q;
          end
        end
        WB_REQ: begin
          if (i_BusGrant) begin
            msi_mem[index] <= MSI_I;
            bus_op_q       <= miss_op;
            bus_addr_q     <= addr_q;
          end
        end
        BUS_REQ: begin
          if (i_BusGrant) begin
            tag_mem[index] <= req_tag;
            msi_mem[index] <= (bus_op_q == OP_READ_MISS) ? MSI_S : MSI_M;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_BusValid     = (state == WB_REQ) || (state == BUS_REQ);
  assign o_CpuReady     = (state == DONE);
  assign o_Busy         = (state != IDLE);
  assign o_BusOperation = bus_op_q;
  assign o_BusAddr      = bus_addr_q;
  assign o_LineState    = (state == DONE) ? line_msi : MSI_I;

endmodule

// File: tb/tb_snoop_emitter.sv
// Self-checking bench for snoop_emitter: directed scenarios plus randomized accesses
// compared against a line-level MSI reference model.
module tb_snoop_emitter;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_CpuValid = 1'b0;
  logic       i_CpuWrite = 1'b0;
  logic [7:0] i_CpuAddr = '0;
  logic       i_BusGrant = 1'b0;
  logic       o_CpuReady, o_Busy, o_BusValid;
  logic [1:0] o_BusOperation, o_LineState;
  logic [7:0] o_BusAddr;

  int checks = 0;
  int failures = 0;

  int         model_msi [4];
  logic [5:0] model_tag [4];
  logic [1:0] exp_op [$];
  logic [7:0] exp_addr [$];
  logic [1:0] exp_ls;
  logic [1:0] obs_op [$];
  logic [7:0] obs_addr [$];

  snoop_emitter dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_CpuValid(i_CpuValid),
    .i_CpuWrite(i_CpuWrite), .i_CpuAddr(i_CpuAddr), .o_CpuReady(o_CpuReady),
    .o_Busy(o_Busy), .o_BusValid(o_BusValid), .o_BusOperation(o_BusOperation),
    .o_BusAddr(o_BusAddr), .i_BusGrant(i_BusGrant), .o_LineState(o_LineState)
  );

  always #5 i_Clock = ~i_Clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      model_msi[i] = 0;
      model_tag[i] = '0;
    end
  endfunction

  // Expected bus traffic and resulting line state from the MSI rules (0=I,1=S,2=M).
  function automatic void predict(input logic wr, input logic [7:0] addr);
    int idx;
    bit hit;
    idx = int'(addr[1:0]);
    hit = (model_msi[idx] != 0) && (model_tag[idx] == addr[7:2]);
    exp_op.delete();
    exp_addr.delete();
    if (hit) begin
      if (wr && model_msi[idx] == 1) begin
        exp_op.push_back(2'd1);
        exp_addr.push_back(addr);
        model_msi[idx] = 2;
      end
    end else begin
`ifdef SNOOP_EMITTER_WRITEBACK_EN
      if (model_msi[idx] == 2) begin
        exp_op.push_back(2'd3);
        exp_addr.push_back({model_tag[idx], addr[1:0]});
      end
`endif
      exp_op.push_back(wr ? 2'd2 : 2'd0);
      exp_addr.push_back(addr);
      model_tag[idx] = addr[7:2];
      model_msi[idx] = wr ? 2 : 1;
    end
    exp_ls = 2'(model_msi[idx]);
  endfunction

  // Drives one CPU access and grants each bus request after gw waiting cycles; records observations.
  task automatic run_access(input logic wr, input logic [7:0] addr, input int gw, input bit poke,
                            output int ready_c, output logic [1:0] ls, output bit busy_ok,
                            output bit stable_ok, output bit excl_ok, output bit timed_out);
    logic [1:0] cap_op;
    logic [7:0] cap_addr;
    bit new_req;
    int waited;
    obs_op.delete();
    obs_addr.delete();
    ready_c = -1; ls = '0; busy_ok = 1; stable_ok = 1; excl_ok = 1; timed_out = 1;
    new_req = 1; waited = 0; cap_op = '0; cap_addr = '0;
    @(negedge i_Clock);
    i_CpuValid = 1'b1;
    i_CpuWrite = wr;
    i_CpuAddr  = addr;
    for (int c = 1; c <= 200; c++) begin
      @(negedge i_Clock);
      i_CpuValid = 1'b0;
      if (i_BusGrant) begin
        obs_op.push_back(cap_op);
        obs_addr.push_back(cap_addr);
        i_BusGrant = 1'b0;
        new_req = 1;
      end
      if (!o_Busy) busy_ok = 0;
      if (o_BusValid && o_CpuReady) excl_ok = 0;
      if (o_CpuReady) begin
        ready_c = c;
        ls = o_LineState;
        timed_out = 0;
        break;
      end
      if (o_BusValid) begin
        if (new_req) begin
          cap_op = o_BusOperation;
          cap_addr = o_BusAddr;
          new_req = 0;
          waited = 0;
        end else if (o_BusOperation !== cap_op || o_BusAddr !== cap_addr) begin
          stable_ok = 0;
        end
        if (waited == gw) i_BusGrant = 1'b1;
        else waited++;
      end
      if (poke) begin
        i_CpuValid = 1'b1;
        i_CpuWrite = 1'($urandom);
        i_CpuAddr  = 8'($urandom);
      end
    end
    i_CpuValid = 1'b0;
    i_BusGrant = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    i_Reset = 1'b1;
    #1;
    checks++;
    if ({o_BusValid, o_CpuReady, o_Busy, o_BusOperation, o_BusAddr, o_LineState} !== 15'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %0h expected 0",
               {o_BusValid, o_CpuReady, o_Busy, o_BusOperation, o_BusAddr, o_LineState});
    end
    repeat (3) @(negedge i_Clock);
    i_Reset = 1'b0;
    @(negedge i_Clock);
    checks++;
    if (o_Busy !== 1'b0 || o_BusValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: busy=%b busvalid=%b expected 0 0", o_Busy, o_BusValid);
    end
  endtask

  task automatic test_directed();
    logic       t_wr [5]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] t_addr [5] = '{8'h14, 8'h14, 8'h14, 8'h24, 8'h33};
    int         t_gw [5]   = '{2, 1, 0, 1, 10};
    bit         t_poke [5] = '{0, 0, 0, 0, 1};
    int ready_c;
    logic [1:0] ls;
    bit busy_ok, stable_ok, excl_ok, timed_out;
    for (int t = 0; t < 5; t++) begin
      predict(t_wr[t], t_addr[t]);
      run_access(t_wr[t], t_addr[t], t_gw[t], t_poke[t], ready_c, ls, busy_ok, stable_ok, excl_ok, timed_out);
      checks++;
      if (timed_out) begin
        failures++;
        $display("[TB] FAIL dir%0d_timeout: no o_CpuReady within budget", t);
      end
      checks++;
      if (obs_op.size() != exp_op.size()) begin
        failures++;
        $display("[TB] FAIL dir%0d_num_ops: got %0d expected %0d", t, obs_op.size(), exp_op.size());
      end
      for (int k = 0; k < exp_op.size() && k < obs_op.size(); k++) begin
        checks++;
        if (obs_op[k] !== exp_op[k] || obs_addr[k] !== exp_addr[k]) begin
          failures++;
          $display("[TB] FAIL dir%0d_op%0d: got op=%0d addr=%0h expected op=%0d addr=%0h",
                   t, k, obs_op[k], obs_addr[k], exp_op[k], exp_addr[k]);
        end
      end
      checks++;
      if (ready_c != 2 + exp_op.size() * (t_gw[t] + 1)) begin
        failures++;
        $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", t, ready_c,
                 2 + exp_op.size() * (t_gw[t] + 1));
      end
      checks++;
      if (ls !== exp_ls) begin
        failures++;
        $display("[TB] FAIL dir%0d_line_state: got %0d expected %0d", t, ls, exp_ls);
      end
      checks++;
      if (!(busy_ok && stable_ok && excl_ok)) begin
        failures++;
        $display("[TB] FAIL dir%0d_handshake: busy=%b stable=%b exclusive=%b expected 1 1 1",
                 t, busy_ok, stable_ok, excl_ok);
      end
      @(negedge i_Clock);
      checks++;
      if (o_Busy !== 1'b0 || o_CpuReady !== 1'b0) begin
        failures++;
        $display("[TB] FAIL dir%0d_back_to_idle: busy=%b ready=%b expected 0 0", t, o_Busy, o_CpuReady);
      end
    end
  endtask

  task automatic test_reset_mid_bus();
    int ready_c;
    logic [1:0] ls;
    bit busy_ok, stable_ok, excl_ok, timed_out;
    bit seen;
    seen = 0;
    @(negedge i_Clock);
    i_CpuValid = 1'b1;
    i_CpuWrite = 1'b0;
    i_CpuAddr  = 8'h5A;
    @(negedge i_Clock);
    i_CpuValid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge i_Clock);
      if (o_BusValid) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL midbus_request: o_BusValid got 0 expected 1");
    end
    #2 i_Reset = 1'b1;
    #1;
    checks++;
    if (o_BusValid !== 1'b0 || o_Busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midbus_async_drop: busvalid=%b busy=%b expected 0 0", o_BusValid, o_Busy);
    end
    @(negedge i_Clock);
    i_Reset = 1'b0;
    model_clear();
    predict(1'b0, 8'h5A);
    run_access(1'b0, 8'h5A, 0, 0, ready_c, ls, busy_ok, stable_ok, excl_ok, timed_out);
    checks++;
    if (obs_op.size() != 1 || obs_op[0] !== 2'd0 || obs_addr[0] !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL midbus_reread_miss: got %0d ops expected 1 READ_MISS at 5a", obs_op.size());
    end
    checks++;
    if (ls !== exp_ls || timed_out) begin
      failures++;
      $display("[TB] FAIL midbus_reread_state: got %0d expected %0d", ls, exp_ls);
    end
    @(negedge i_Clock);
  endtask

  task automatic test_random();
    int ready_c, gw;
    logic [1:0] ls;
    logic wr;
    logic [7:0] addr;
    bit busy_ok, stable_ok, excl_ok, timed_out;
    for (int t = 0; t < 40; t++) begin
      wr   = 1'($urandom);
      addr = {4'h0, 2'($urandom), 2'($urandom)};
      gw   = int'($urandom_range(0, 3));
      predict(wr, addr);
      run_access(wr, addr, gw, 1'($urandom), ready_c, ls, busy_ok, stable_ok, excl_ok, timed_out);
      checks++;
      if (obs_op != exp_op || obs_addr != exp_addr || timed_out) begin
        failures++;
        $display("[TB] FAIL rnd%0d_ops: wr=%b addr=%0h got %0d ops expected %0d ops (timeout=%b)",
                 t, wr, addr, obs_op.size(), exp_op.size(), timed_out);
      end
      checks++;
      if (ls !== exp_ls || ready_c != 2 + exp_op.size() * (gw + 1)) begin
        failures++;
        $display("[TB] FAIL rnd%0d_result: state=%0d latency=%0d expected state=%0d latency=%0d",
                 t, ls, ready_c, exp_ls, 2 + exp_op.size() * (gw + 1));
      end
      checks++;
      if (!(busy_ok && stable_ok && excl_ok)) begin
        failures++;
        $display("[TB] FAIL rnd%0d_handshake: busy=%b stable=%b exclusive=%b expected 1 1 1",
                 t, busy_ok, stable_ok, excl_ok);
      end
      @(negedge i_Clock);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_bus();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
